dram_cmd_arbiter: RTL

Round-robin arbiter that shares the single DRAM command FSM between `NREQ` requesters (for example the tensor-core load and store units and a host port). It owns the `dREN`/`dWEN`/address inputs of the command FSM and grants one transaction at a time. It watches `ram_wait` to detect completion and returns a one-cycle `done` pulse to the winning requester. It yields to pending refresh by not starting new transactions while `rf_req` is high.

---
 rtl/dram_cmd_arbiter_if.sv | 27 ++
 rtl/dram_cmd_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/dram_cmd_arbiter_if.sv
// dram_cmd_arbiter_if: requester and command-FSM signals shared by the DRAM arbiter.
// master is the arbiter side; slave is the requester / command-FSM side.
interface dram_cmd_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 32
);
    logic [NREQ-1:0]        req_ren;
    logic [NREQ-1:0]        req_wen;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic                   dREN;
    logic                   dWEN;
    logic [ADDR_W-1:0]      daddr;
    logic                   ram_wait;
    logic                   rf_req;

    modport master (
        input  req_ren, req_wen, req_addr, ram_wait, rf_req,
        output grant, done, dREN, dWEN, daddr
    );

    modport slave (
        output req_ren, req_wen, req_addr, ram_wait, rf_req,
        input  grant, done, dREN, dWEN, daddr
    );
endinterface

// File: rtl/dram_cmd_arbiter.sv
// dram_cmd_arbiter: round-robin owner of the DRAM command FSM request inputs, one transaction at a time.
// Defining DRAM_ARB_ROWHIT_EN adds a bounded preference for requests hitting the last granted row.
module dram_cmd_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 32,
    parameter int ROW_LSB = 13,
    parameter int MAX_HIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    dram_cmd_arbiter_if.master bus
);
`ifdef DRAM_ARB_ROWHIT_EN
    localparam bit ROWHIT = 1'b1;
`else
    localparam bit ROWHIT = 1'b0;
`endif
    localparam int PW = $clog2(NREQ);
    localparam int RW = ADDR_W - ROW_LSB;
    localparam int CW = $clog2(MAX_HIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d, sel_q, sel_d, win;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d, daddr_q;
    logic [RW-1:0]     last_row_q, last_row_d;
    logic [CW-1:0]     hit_cnt_q, hit_cnt_d;
    logic [NREQ-1:0]   active, hit_m;
    logic [NREQ-1:0]   grant_q, grant_d, done_q, done_d;
    logic              dren_q, dren_d, dwen_q, dwen_d;
    logic              start, hit_grant;

    // First set bit of m searching upward from p with wrap-around.
    function automatic logic [PW-1:0] pick(input logic [NREQ-1:0] m, input logic [PW-1:0] p);
        pick = p;
        for (int j = NREQ - 1; j >= 0; j--)
            if (m[(int'(p) + j) % NREQ]) pick = PW'((int'(p) + j) % NREQ);
    endfunction

    assign active = bus.req_ren | bus.req_wen;
    assign start  = state_q == IDLE && |active && !bus.rf_req;

    always_comb begin
        hit_m = '0;
        for (int i = 0; i < NREQ; i++)
            hit_m[i] = active[i] && bus.req_addr[i*ADDR_W+ROW_LSB +: RW] == last_row_q;
    end

    assign hit_grant = ROWHIT && |hit_m && hit_cnt_q < CW'(MAX_HIT);
    assign win       = hit_grant ? pick(hit_m, rr_ptr_q) : pick(active, rr_ptr_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            last_row_q <= '0;
            hit_cnt_q  <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            dren_q     <= 1'b0;
            dwen_q     <= 1'b0;
            daddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            last_row_q <= last_row_d;
            hit_cnt_q  <= hit_cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            dren_q     <= dren_d;
            dwen_q     <= dwen_d;
            daddr_q    <= addr_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        last_row_d = last_row_q;
        hit_cnt_d  = hit_cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = ISSUE;
                sel_d      = win;
                wr_d       = bus.req_wen[win];
                addr_d     = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
                last_row_d = addr_d[ADDR_W-1:ROW_LSB];
                hit_cnt_d  = hit_grant ? hit_cnt_q + CW'(1) : '0;
            end
            ISSUE: if (bus.ram_wait) state_d = BUSY;
            BUSY:  if (!bus.ram_wait) state_d = DONE;
            default: begin
                state_d  = IDLE;
                rr_ptr_d = sel_q == PW'(NREQ - 1) ? '0 : sel_q + PW'(1);
            end
        endcase
    end

    // Outputs are decoded from the current state and registered, so they trail the state by one cycle.
    always_comb begin
        grant_d = state_q == IDLE ? '0 : NREQ'(1) << sel_q;
        done_d  = state_q == DONE ? grant_d : '0;
        dren_d  = (state_q == ISSUE || state_q == BUSY) && !wr_q;
        dwen_d  = (state_q == ISSUE || state_q == BUSY) && wr_q;
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.dREN  = dren_q;
    assign bus.dWEN  = dwen_q;
    assign bus.daddr = daddr_q;
endmodule
